decoder_grant_arbiter: RTL
==========================

# decoder_grant_arbiter

Eight-way round-robin arbiter that shares one resource among eight requesters and drives a 3-to-8 decoder-style one-hot grant bus. It selects a winner index (3 bits), registers it, and presents both the index and its decoded one-hot form. A hold-limit counter forces rotation, so a requester cannot monopolise the resource while others wait. It sits between requesting lab blocks and the shared resource they contend for.

## Interface
- MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when another requester is waiting; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  arbitration enable; low blocks new grants and preemption.
- req  input  8  request vector; bit i = requester i.
- grant  output  8  one-hot grant, equal to decode(sel) when valid=1, else 8'h00.
- sel  output  3  winning index; holds its last value when idle, acting as the round-robin pointer.
- valid  output  1  a grant is active.

## Operation
- States: IDLE, BUSY. Internal hold counter `cnt` is 4 bits wide.
- Reset (rst_n=0 at a clk edge): state=IDLE, sel=3'b111, grant=8'h00, valid=0, cnt=0.
- Search order: (sel+1), (sel+2), … (sel+8), all mod 8. The first asserted bit wins. Starting from reset, index 0 has highest priority.
- Exclusion search: the same order, ignoring bit sel.
- IDLE:
  - If en=1 and req≠0, load the winner into sel, set valid=1, grant=1<<winner, cnt=1, and move to BUSY.
  - Otherwise remain in IDLE with all outputs unchanged.
- BUSY, evaluated in priority order:
  1. If req[sel]=0 (release) and en=1 and another request exists, grant the next winner in the same edge with cnt=1 and stay in BUSY (back-to-back).
  2. If req[sel]=0 otherwise, move to IDLE with valid=0 and grant=0; sel is retained.
  3. If req[sel]=1, en=1, cnt==MAX_HOLD, and the exclusion search finds a requester, preempt to it with cnt=1.
  4. If req[sel]=1 otherwise, keep the grant; cnt increments and saturates at MAX_HOLD.
- en=0 never revokes an active grant. Release still returns the block to IDLE.
- grant is always zero or exactly one-hot. It never has more than one bit set.

## Timing
- All outputs are registered. They change only on rising clk edges.
- Grant latency: a req sampled at edge N with the block idle produces grant valid after edge N. That is one cycle from request assertion to grant.
- Release-to-next-grant takes 0 idle cycles; the handover occurs at the edge that samples the release.
- Preemption: a requester that holds continuously while others wait owns the resource for exactly MAX_HOLD cycles.
- Simultaneous release of the current owner and new requests: the new requests are arbitrated at the same edge, per BUSY rule 1.
- Reset mid-grant: at the next edge, grant=0, valid=0, sel=7. Reset overrides all other inputs.
- req bits for non-winners may toggle freely. Only the value at a sampling edge matters.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=8'hFF → grant=8'h00, valid=0, sel=3'b111.
- Single request: en=1, req=8'h20 → one cycle later grant=8'h20, sel=5, valid=1. Drop req → next edge grant=8'h00, valid=0, sel=5.
- Round robin: req=8'hFF; each owner drops its req for one cycle after 1 cycle of grant → sel sequence 0,1,2,…,7,0 and grant sequence 8'h01,8'h02,…,8'h80,8'h01.
- Preemption with MAX_HOLD=4: req=8'h05 held constant → grant=8'h01 for 4 cycles, then 8'h04 for 4 cycles, then 8'h01, and so on. With req=8'h01 alone, grant stays 8'h01 indefinitely.
- en gating:
  - In IDLE with en=0 and req=8'h10 → grant stays 8'h00.
  - In BUSY with owner 2, then en dropped with req=8'h0C held past MAX_HOLD → no preemption; grant stays 8'h04.
- Reset mid-operation: grant=8'h08 active, assert rst_n=0 for 1 cycle → grant=8'h00, sel=7. Release reset with req=8'h09 → next grant=8'h01.

Source files
------------

// File: rtl/decoder_grant_arbiter.sv
// Eight-way round-robin arbiter with registered 3-bit winner index and one-hot grant.
// A hold counter forces rotation to a waiting requester after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no grant active, sel holds the round-robin pointer
// BUSY  | requester sel owns the resource, cnt counts consecutive cycles
module decoder_grant_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [2:0] sel_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] grant_nxt;

  logic       found, found_x;
  logic [2:0] win, win_x, idx, idx_x;

  // Full search visits sel last; the exclusion search skips it entirely.
  always_comb begin
    found   = 1'b0;
    win     = sel;
    idx     = sel;
    found_x = 1'b0;
    win_x   = sel;
    idx_x   = sel;
    for (int k = 1; k <= 8; k++) begin
      idx = sel + k[2:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int k = 1; k <= 7; k++) begin
      idx_x = sel + k[2:0];
      if (!found_x && req[idx_x]) begin
        found_x = 1'b1;
        win_x   = idx_x;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (en && found) begin
          sel_nxt   = win;
          cnt_nxt   = 4'd1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!req[sel]) begin
          if (en && found) begin
            sel_nxt = win;
            cnt_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (en && cnt == HOLD_MAX && found_x) begin
          sel_nxt = win_x;
          cnt_nxt = 4'd1;
        end else if (cnt < HOLD_MAX) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    grant_nxt = (state_nxt == BUSY) ? (8'h01 << sel_nxt) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'b111;
      cnt   <= 4'd0;
      grant <= 8'h00;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      grant <= grant_nxt;
    end
  end

  assign valid = (state == BUSY);

endmodule
